// File: rtl/serout_shifter.sv
// serout_shifter: POKEY SEROUT transmitter framing start/8 data LSB-first/stop bits onto sout per serial bit tick.
module serout_shifter (
  input  logic       clk,
  input  logic       reset,
  input  logic       enp,
  input  logic       wr_serout,
  input  logic [7:0] din,
  input  logic       bit_tick,
  input  logic       sbreak,
  output logic       sout,
  output logic       odn,
  output logic       xmtdone,
  output logic       busy
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nx;
  logic [7:0] hold;
  logic hold_full;
  logic [9:0] frm;
  logic [3:0] cnt;
  logic tick, last, xfer, fin;
  always_comb begin
    tick = bit_tick & enp;
    last = (state == SHIFT) && (cnt == 4'd9);
    xfer = tick & hold_full & ((state == IDLE) | last);
    fin = tick & ~hold_full & last;
    state_nx = xfer ? SHIFT : fin ? IDLE : state;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // A write in the transfer cycle still lands: hold_full and xmtdone favour the write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold <= '0;
      hold_full <= 1'b0;
      frm <= '1;
      cnt <= '0;
      xmtdone <= 1'b1;
    end else begin
      if (xfer) begin
        frm <= {1'b1, hold, 1'b0};
        cnt <= '0;
      end else if (fin) begin
        frm <= '1;
      end else if (tick && state == SHIFT) begin
        frm <= {1'b1, frm[9:1]};
        cnt <= cnt + 4'd1;
      end
      if (wr_serout) hold <= din;
      hold_full <= wr_serout | (hold_full & ~xfer);
      xmtdone <= ~wr_serout & (xmtdone | fin);
    end
  end
  assign odn = xfer;
  assign busy = (state == SHIFT);
  assign sout = frm[0] & ~sbreak;
endmodule

// File: tb/tb_serout_shifter.sv
// tb_serout_shifter: directed and random stimulus against a queue-based line model of the SEROUT transmitter.
module tb_serout_shifter;
  logic clk = 1'b0, reset = 1'b1, enp = 1'b0, wr_serout = 1'b0, bit_tick = 1'b0, sbreak = 1'b0;
  logic [7:0] din = '0;
  logic sout, odn, xmtdone, busy;
  int errors = 0, checks = 0, odn_cnt = 0;
  logic last_sout;
  logic [9:0] seq;
  int odn0;
  bit q[$];
  logic [7:0] hold_m = '0;
  bit full_m = 1'b0, xd_m = 1'b1;

  serout_shifter dut (
    .clk(clk), .reset(reset), .enp(enp), .wr_serout(wr_serout), .din(din),
    .bit_tick(bit_tick), .sbreak(sbreak), .sout(sout), .odn(odn), .xmtdone(xmtdone), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [9:0] o, input logic [9:0] x);
    checks++;
    assert (o === x) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, o, x);
    end
  endtask

  task automatic model_reset();
    q.delete();
    hold_m = '0;
    full_m = 1'b0;
    xd_m = 1'b1;
  endtask

  // One clk cycle: drive inputs, check outputs against the model, then advance the model at the edge.
  task automatic step(input bit w, input logic [7:0] d, input bit t, input bit e, input bit b);
    bit tk, xf;
    @(negedge clk);
    wr_serout = w; din = d; bit_tick = t; enp = e; sbreak = b;
    #1;
    tk = t && e;
    xf = tk && full_m && q.size() <= 1;
    chk("sout", {9'd0, sout}, {9'd0, (q.size() > 0 ? q[0] : 1'b1) & ~b});
    chk("busy", {9'd0, busy}, {9'd0, q.size() > 0});
    chk("xmtdone", {9'd0, xmtdone}, {9'd0, xd_m});
    chk("odn", {9'd0, odn}, {9'd0, xf});
    last_sout = sout;
    if (odn === 1'b1) odn_cnt++;
    @(posedge clk);
    if (xf) begin
      q.delete();
      q.push_back(1'b0);
      for (int i = 0; i < 8; i++) q.push_back(hold_m[i]);
      q.push_back(1'b1);
      full_m = 1'b0;
    end else if (tk && q.size() == 1) begin
      void'(q.pop_front());
      xd_m = 1'b1;
    end else if (tk && q.size() > 1) begin
      void'(q.pop_front());
    end
    if (w) begin
      hold_m = d;
      full_m = 1'b1;
      xd_m = 1'b0;
    end
  endtask

  task automatic ticks(input int n, input bit b);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b1, b);
  endtask

  task automatic send_capture(input logic [7:0] d, output logic [9:0] s);
    step(1'b1, d, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      s[i] = last_sout;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    // single frame
    odn0 = odn_cnt;
    send_capture(8'hA5, seq);
    chk("a5_frame", seq, 10'b1101001010);
    chk("a5_odn", odn_cnt - odn0, 1);
    ticks(2, 1'b0);

    // back-to-back
    odn0 = odn_cnt;
    step(1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0); seq[i] = last_sout; end
    chk("b2b_first", seq, 10'b1000000000);
    for (int i = 0; i < 10; i++) begin step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0); seq[i] = last_sout; end
    chk("b2b_second", seq, 10'b1111111110);
    chk("b2b_odn", odn_cnt - odn0, 2);
    ticks(2, 1'b0);

    // coincident write+tick while idle, then write during a transfer tick
    odn0 = odn_cnt;
    step(1'b1, 8'h3C, 1'b1, 1'b1, 1'b0);
    chk("coinc_no_xfer", odn_cnt - odn0, 0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("coinc_xfer", odn_cnt - odn0, 1);
    step(1'b1, 8'h81, 1'b0, 1'b1, 1'b0);
    ticks(9, 1'b0);
    step(1'b1, 8'h5A, 1'b1, 1'b1, 1'b0);
    ticks(23, 1'b0);
    chk("coinc_odn", odn_cnt - odn0, 3);

    // overwrite before tick
    odn0 = odn_cnt;
    step(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
    send_capture(8'h22, seq);
    chk("ovw_frame", seq, 10'b1001000100);
    chk("ovw_odn", odn_cnt - odn0, 1);
    ticks(2, 1'b0);

    // break and enable gating mid-frame
    step(1'b1, 8'hF0, 1'b0, 1'b1, 1'b0);
    ticks(3, 1'b0);
    ticks(3, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    ticks(8, 1'b0);

    // asynchronous reset mid-frame
    step(1'b1, 8'h96, 1'b0, 1'b1, 1'b0);
    ticks(4, 1'b0);
    @(negedge clk);
    wr_serout = 1'b0; bit_tick = 1'b0; sbreak = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_sout", {9'd0, sout}, 10'd1);
    chk("rst_busy", {9'd0, busy}, 10'd0);
    chk("rst_xmtdone", {9'd0, xmtdone}, 10'd1);
    chk("rst_odn", {9'd0, odn}, 10'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    ticks(3, 1'b0);

    // random
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 9) == 0, 8'($urandom), $urandom_range(0, 2) == 0,
           $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0);
    ticks(25, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
